// File: rtl/hamming_secded_codec_if.sv
// Valid/ready stream bundle of the SEC-DED codec: the accepted input word and the delivered result word.
interface hamming_secded_codec_if #(
    parameter int unsigned DATA_W = 4
);
    // Smallest r with 2**r >= dw + r + 1
    function automatic int unsigned calc_par_w(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (r == 0 && (32'd1 << i) >= dw + i + 1) r = i;
        end
        return r;
    endfunction

    localparam int unsigned PAR_W  = calc_par_w(DATA_W);
    localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [CODE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_mode;
    logic [CODE_W-1:0] out_data;
    logic [PAR_W-1:0]  out_syndrome;
    logic              out_err_single;
    logic              out_err_double;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_syndrome,
               out_err_single, out_err_double
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_syndrome,
               out_err_single, out_err_double
    );
endinterface

// File: rtl/hamming_secded_codec.sv
// Two-stage streaming Hamming SEC-DED encoder/decoder with per-word mode and saturating error counters.
module hamming_secded_codec #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hamming_secded_codec_if.slave    bus,
    input  logic                     clr_cnt,
    output logic [CNT_W-1:0]         cnt_single,
    output logic [CNT_W-1:0]         cnt_double
);
    function automatic int unsigned calc_par_w(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (r == 0 && (32'd1 << i) >= dw + i + 1) r = i;
        end
        return r;
    endfunction

    localparam int unsigned PAR_W  = calc_par_w(DATA_W);
    localparam int unsigned CODE_W = DATA_W + PAR_W + 1;
    localparam int unsigned IDX_W  = $clog2(CODE_W);

    // Codeword position of data bit idx: the idx-th non-power-of-two position from 1
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    typedef struct packed {
        logic              mode;
        logic [CODE_W-1:0] word;
        logic [PAR_W-1:0]  syn;
        logic              par;
    } s1_t;

    logic              s1_valid;
    s1_t               s1_q;
    s1_t               s1_d;
    logic              s1_adv;
    logic              out_xfer;

    logic [CODE_W-1:0] spread_w;
    logic [CODE_W-1:0] enc_word;
    logic [PAR_W-1:0]  in_syn;
    logic              in_par;

    logic [CODE_W-1:0] fixed_w;
    logic [CODE_W-1:0] res_data;
    logic              res_single;
    logic              res_double;

    // Place the data bits at their Hamming positions, parity positions left zero
    always_comb begin
        spread_w = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            spread_w[IDX_W'(data_pos(i))] = bus.in_data[IDX_W'(i)];
        end
    end

    always_comb begin
        enc_word = spread_w;
        for (int unsigned k = 0; k < PAR_W; k++) begin
            for (int unsigned p = 1; p < CODE_W; p++) begin
                if (((p >> k) & 32'd1) != 0)
                    enc_word[IDX_W'(32'd1 << k)] ^= spread_w[IDX_W'(p)];
            end
        end
        enc_word[0] = ^enc_word[CODE_W-1:1];
    end

    // Syndrome is the XOR of the indices of all set positions
    always_comb begin
        in_syn = '0;
        for (int unsigned p = 1; p < CODE_W; p++) begin
            if (bus.in_data[IDX_W'(p)]) in_syn ^= PAR_W'(p);
        end
    end

    assign in_par = ^bus.in_data;

    always_comb begin
        s1_d      = '0;
        s1_d.mode = bus.in_mode;
        s1_d.word = bus.in_mode ? bus.in_data : enc_word;
        s1_d.syn  = bus.in_mode ? in_syn : '0;
        s1_d.par  = bus.in_mode ? in_par : 1'b0;
    end

    // Stage-2 correction: only a single error at a real position is flipped
    always_comb begin
        int unsigned syn_ext;
        fixed_w    = s1_q.word;
        res_single = 1'b0;
        res_double = 1'b0;
        syn_ext    = 32'(s1_q.syn);
        if (s1_q.mode) begin
            if (s1_q.par) begin
                if (syn_ext > CODE_W - 1) begin
                    res_double = 1'b1;
                end else begin
                    res_single = 1'b1;
                    if (syn_ext != 0)
                        fixed_w[IDX_W'(s1_q.syn)] = ~s1_q.word[IDX_W'(s1_q.syn)];
                end
            end else if (syn_ext != 0) begin
                res_double = 1'b1;
            end
        end
    end

    // Decode result is the data field of the (possibly corrected) word, zero-extended
    always_comb begin
        res_data = '0;
        if (s1_q.mode) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                res_data[IDX_W'(i)] = fixed_w[IDX_W'(data_pos(i))];
            end
        end else begin
            res_data = s1_q.word;
        end
    end

    assign s1_adv      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s1_adv;
    assign out_xfer    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) s1_q <= s1_d;
        end
    end

    // Output register holds its word while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid      <= 1'b0;
            bus.out_mode       <= 1'b0;
            bus.out_data       <= '0;
            bus.out_syndrome   <= '0;
            bus.out_err_single <= 1'b0;
            bus.out_err_double <= 1'b0;
        end else if (s1_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_mode       <= s1_q.mode;
                bus.out_data       <= res_data;
                bus.out_syndrome   <= s1_q.syn;
                bus.out_err_single <= res_single;
                bus.out_err_double <= res_double;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (clr_cnt) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else begin
            if (out_xfer && bus.out_err_single && cnt_single != '1)
                cnt_single <= cnt_single + CNT_W'(1);
            if (out_xfer && bus.out_err_double && cnt_double != '1)
                cnt_double <= cnt_double + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for hamming_secded_codec at DATA_W=4: an 8-bit-counter instance and a 2-bit-counter instance.
module tb_hamming_secded_codec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       clr_a;
    logic       clr_b;
    logic [7:0] cnt_single_a;
    logic [7:0] cnt_double_a;
    logic [1:0] cnt_single_b;
    logic [1:0] cnt_double_b;

    int n_cmp = 0;
    int n_bad = 0;

    hamming_secded_codec_if #(.DATA_W(4)) bus_a ();
    hamming_secded_codec_if #(.DATA_W(4)) bus_b ();

    hamming_secded_codec #(.DATA_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr_cnt(clr_a),
        .cnt_single(cnt_single_a), .cnt_double(cnt_double_a)
    );

    hamming_secded_codec #(.DATA_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr_cnt(clr_b),
        .cnt_single(cnt_single_b), .cnt_double(cnt_double_b)
    );

    // Drives one word into dut_a with out_ready high and captures the first result (bounded wait)
    task automatic xfer_a(input logic mode, input logic [7:0] din, output logic got,
                          output int lat, output logic [7:0] od, output logic [2:0] os,
                          output logic om, output logic es, output logic ed);
        got = 1'b0; lat = 0; od = '0; os = '0; om = 1'b0; es = 1'b0; ed = 1'b0;
        @(negedge clk);
        bus_a.in_valid = 1'b1; bus_a.in_mode = mode; bus_a.in_data = din; bus_a.out_ready = 1'b1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            if (!got) begin
                if (bus_a.out_valid) begin
                    got = 1'b1; od = bus_a.out_data; os = bus_a.out_syndrome;
                    om = bus_a.out_mode; es = bus_a.out_err_single; ed = bus_a.out_err_double;
                end else begin
                    @(negedge clk);
                    lat++;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus_a.in_valid = 1'b0; bus_a.in_mode = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_mode = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus_a.out_valid, bus_a.out_mode, bus_a.out_err_single, bus_a.out_err_double} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 0000",
                {bus_a.out_valid, bus_a.out_mode, bus_a.out_err_single, bus_a.out_err_double});
        end
        n_cmp++;
        if (bus_a.out_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_data: got %h expected 00", bus_a.out_data);
        end
        n_cmp++;
        if (bus_a.out_syndrome !== 3'd0) begin
            n_bad++; $display("FAIL reset_syn: got %0d expected 0", bus_a.out_syndrome);
        end
        n_cmp++;
        if ({cnt_single_a, cnt_double_a, cnt_single_b, cnt_double_b} !== 20'h0) begin
            n_bad++; $display("FAIL reset_cnt: got %h expected 0",
                {cnt_single_a, cnt_double_a, cnt_single_b, cnt_double_b});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b%b expected 11", bus_a.in_ready, bus_b.in_ready);
        end
        n_cmp++;
        if (bus_a.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid_after: got %b expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_encode();
        logic [7:0] din [5];
        logic [7:0] exp_cw [5];
        logic got, om, es, ed;
        logic [7:0] od;
        logic [2:0] os;
        int lat;
        din    = '{8'h0B, 8'h00, 8'h0F, 8'h01, 8'hFB};
        exp_cw = '{8'hAA, 8'h00, 8'hFF, 8'h0F, 8'hAA};
        for (int v = 0; v < 5; v++) begin
            xfer_a(1'b0, din[v], got, lat, od, os, om, es, ed);
            n_cmp++;
            if (got !== 1'b1 || lat != 2) begin
                n_bad++; $display("FAIL enc_latency[%0d]: got valid=%b lat=%0d expected valid=1 lat=2", v, got, lat);
            end
            n_cmp++;
            if (od !== exp_cw[v]) begin
                n_bad++; $display("FAIL enc_data[%0d]: got %h expected %h", v, od, exp_cw[v]);
            end
            n_cmp++;
            if ({os, om, es, ed} !== 6'b0) begin
                n_bad++; $display("FAIL enc_side[%0d]: got syn=%0d mode=%b s=%b d=%b expected all 0", v, os, om, es, ed);
            end
        end
    endtask

    task automatic test_decode();
        logic [7:0] din [4];
        logic [7:0] exp_d [4];
        logic [2:0] exp_s [4];
        logic       exp_es [4];
        logic       exp_ed [4];
        logic got, om, es, ed;
        logic [7:0] od;
        logic [2:0] os;
        int lat;
        int exp_cs, exp_cd;
        din    = '{8'hAA, 8'h8A, 8'h82, 8'hAB};
        exp_d  = '{8'h0B, 8'h0B, 8'h08, 8'h0B};
        exp_s  = '{3'd0, 3'd5, 3'd6, 3'd0};
        exp_es = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_ed = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_cs = 0; exp_cd = 0;
        for (int v = 0; v < 4; v++) begin
            xfer_a(1'b1, din[v], got, lat, od, os, om, es, ed);
            n_cmp++;
            if (got !== 1'b1 || lat != 2 || om !== 1'b1) begin
                n_bad++; $display("FAIL dec_valid[%0d]: got valid=%b lat=%0d mode=%b expected 1/2/1", v, got, lat, om);
            end
            n_cmp++;
            if (od !== exp_d[v] || os !== exp_s[v]) begin
                n_bad++; $display("FAIL dec_data[%0d]: got %h syn %0d expected %h syn %0d", v, od, os, exp_d[v], exp_s[v]);
            end
            n_cmp++;
            if (es !== exp_es[v] || ed !== exp_ed[v]) begin
                n_bad++; $display("FAIL dec_flags[%0d]: got s=%b d=%b expected s=%b d=%b", v, es, ed, exp_es[v], exp_ed[v]);
            end
            @(negedge clk);
            exp_cs += int'(exp_es[v]);
            exp_cd += int'(exp_ed[v]);
            n_cmp++;
            if (cnt_single_a !== 8'(exp_cs) || cnt_double_a !== 8'(exp_cd)) begin
                n_bad++; $display("FAIL dec_cnt[%0d]: got %0d/%0d expected %0d/%0d", v, cnt_single_a, cnt_double_a, exp_cs, exp_cd);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w [3];
        logic [7:0] e [3];
        logic [7:0] got_q [$];
        logic [7:0] held;
        logic have_held, flag, ir_at_hold;
        int k, unstable, acc_at_hold;
        w = '{8'h01, 8'h0B, 8'h0F};
        e = '{8'h0F, 8'hAA, 8'hFF};
        k = 0; flag = 1'b0; have_held = 1'b0; unstable = 0; held = '0;
        acc_at_hold = -1; ir_at_hold = 1'bx;
        @(negedge clk);
        bus_a.out_ready = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (flag) k++;
            if (cyc == 5) begin
                acc_at_hold = k; ir_at_hold = bus_a.in_ready; bus_a.out_ready = 1'b1;
            end
            if (cyc < 5 && bus_a.out_valid) begin
                if (!have_held) begin held = bus_a.out_data; have_held = 1'b1; end
                else if (bus_a.out_data !== held) unstable++;
            end
            if (bus_a.out_valid && bus_a.out_ready) got_q.push_back(bus_a.out_data);
            if (k < 3) begin
                bus_a.in_valid = 1'b1; bus_a.in_mode = 1'b0; bus_a.in_data = w[k];
            end else begin
                bus_a.in_valid = 1'b0;
            end
            #1;
            flag = bus_a.in_valid && bus_a.in_ready;
        end
        n_cmp++;
        if (acc_at_hold != 2 || ir_at_hold !== 1'b0) begin
            n_bad++; $display("FAIL bp_accept: got %0d words in_ready=%b expected 2 words in_ready=0", acc_at_hold, ir_at_hold);
        end
        n_cmp++;
        if (have_held !== 1'b1 || unstable != 0) begin
            n_bad++; $display("FAIL bp_stable: got held=%b changes=%0d expected held=1 changes=0", have_held, unstable);
        end
        n_cmp++;
        if (got_q.size() != 3) begin
            n_bad++; $display("FAIL bp_count: got %0d words expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_q[i] !== e[i]) begin
                    n_bad++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_q[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_counter_sat();
        int vcnt;
        bit seen;
        vcnt = 0;
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_b.out_valid) vcnt++;
            bus_b.in_valid = 1'b1; bus_b.in_mode = 1'b1; bus_b.in_data = 8'h8A;
        end
        @(negedge clk);
        if (bus_b.out_valid) vcnt++;
        bus_b.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus_b.out_valid) vcnt++;
        end
        n_cmp++;
        if (vcnt != 5) begin
            n_bad++; $display("FAIL b2b_words: got %0d expected 5", vcnt);
        end
        n_cmp++;
        if (cnt_single_b !== 2'd3 || cnt_double_b !== 2'd0) begin
            n_bad++; $display("FAIL sat_cnt: got %0d/%0d expected 3/0", cnt_single_b, cnt_double_b);
        end
        // Clear coinciding with a single-error delivery
        @(negedge clk);
        bus_b.in_valid = 1'b1; bus_b.in_data = 8'h8A;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!seen) begin
                if (bus_b.out_valid) begin seen = 1'b1; clr_b = 1'b1; end
                else @(negedge clk);
            end
        end
        @(negedge clk);
        clr_b = 1'b0;
        n_cmp++;
        if (seen !== 1'b1 || cnt_single_b !== 2'd0) begin
            n_bad++; $display("FAIL clr_wins: got seen=%b cnt=%0d expected seen=1 cnt=0", seen, cnt_single_b);
        end
        @(negedge clk);
        bus_b.in_valid = 1'b1; bus_b.in_data = 8'hAB;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cnt_single_b !== 2'd1) begin
            n_bad++; $display("FAIL cnt_after_clr: got %0d expected 1", cnt_single_b);
        end
    endtask

    task automatic test_reset_midstream();
        int stale;
        stale = 0;
        @(negedge clk);
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_mode = 1'b0; bus_a.in_data = 8'h01;
        @(negedge clk);
        bus_a.in_data = 8'h0B;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        n_cmp++;
        if (bus_a.out_valid !== 1'b1 || cnt_single_a !== 8'd2 || cnt_double_a !== 8'd1) begin
            n_bad++; $display("FAIL pre_reset: got valid=%b cnt=%0d/%0d expected 1 cnt=2/1", bus_a.out_valid, cnt_single_a, cnt_double_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || bus_a.out_data !== 8'h00) begin
            n_bad++; $display("FAIL mid_reset: got valid=%b ready=%b data=%h expected 0/1/00", bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
        end
        n_cmp++;
        if (cnt_single_a !== 8'd0 || cnt_double_a !== 8'd0) begin
            n_bad++; $display("FAIL mid_reset_cnt: got %0d/%0d expected 0/0", cnt_single_a, cnt_double_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.out_valid) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_bad++; $display("FAIL stale_word: got %0d valid cycles expected 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode();
        test_backpressure();
        test_counter_sat();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
        $fatal(1);
    end
endmodule
